// File: rtl/inst_mem_resp_if.sv
// rtl/inst_mem_resp_if.sv - fetch, loader and status signals of inst_mem_resp
interface inst_mem_resp_if #(
    parameter int ADDR_W = 10
);
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              ld_start_i;
    logic [ADDR_W:0]   ld_len_i;
    logic              ld_valid_i;
    logic [7:0]        ld_data_i;
    logic              ld_ready_o;
    logic              ld_busy_o;
    logic              ld_done_o;
    logic              cpu_rst_o;
    logic              err_o;

    modport master (
        output rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_data_i,
        input  rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, cpu_rst_o, err_o
    );

    modport slave (
        input  rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_data_i,
        output rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, cpu_rst_o, err_o
    );
endinterface

// File: rtl/inst_mem_resp.sv
// rtl/inst_mem_resp.sv - instruction ROM responder with byte-stream loader
// INST_MEM_LE_EN selects little-endian byte assembly (default big-endian).
module inst_mem_resp #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    inst_mem_resp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W:0]     len;
    logic [ADDR_W:0]     len_clamped;
    logic [ADDR_W-1:0]   word_cnt;
    logic [1:0]          byte_cnt;
    logic [23:0]         asm_q;
    logic [23:0]         asm_nxt;
    logic [31:0]         word_nxt;
    logic                xfer;
    logic                word_wr;
    logic                last_word;
    logic                out_of_range;
    logic                err;
    logic [ADDR_W-1:0]   rd_idx;
    logic                unused_addr_lsb;

    assign xfer      = (state == LOAD) && bus.ld_valid_i;
    assign word_wr   = xfer && (byte_cnt == 2'd3);
    assign last_word = ({1'b0, word_cnt} == (len - {{ADDR_W{1'b0}}, 1'b1}));

    assign len_clamped = bus.ld_len_i[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : bus.ld_len_i;

    // Only three bytes need holding; the fourth goes straight into the written word.
`ifdef INST_MEM_LE_EN
    assign asm_nxt  = {bus.ld_data_i, asm_q[23:8]};
    assign word_nxt = {bus.ld_data_i, asm_q};
`else
    assign asm_nxt  = {asm_q[15:0], bus.ld_data_i};
    assign word_nxt = {asm_q, bus.ld_data_i};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.ld_start_i) begin
                    state_nxt = (bus.ld_len_i == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (word_wr && last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && bus.ld_start_i) begin
                len      <= len_clamped;
                word_cnt <= '0;
                byte_cnt <= '0;
            end else if (xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_q    <= asm_nxt;
                if (word_wr) begin
                    word_cnt <= word_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            if (bus.rom_ce_i && state != LOAD && out_of_range) begin
                err <= 1'b1;
            end
        end
    end

    // Array is deliberately left out of reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[word_cnt] <= word_nxt;
        end
    end

    assign rd_idx          = bus.rom_addr_i[ADDR_W+1:2];
    assign out_of_range    = |bus.rom_addr_i[31:ADDR_W+2];
    assign unused_addr_lsb = ^bus.rom_addr_i[1:0];

    assign bus.rom_data_o = (bus.rom_ce_i && state != LOAD && !out_of_range) ? mem[rd_idx] : '0;
    assign bus.ld_ready_o = (state == LOAD);
    assign bus.ld_busy_o  = (state == LOAD);
    assign bus.ld_done_o  = (state == DONE);
    assign bus.cpu_rst_o  = rst || (state == LOAD);
    assign bus.err_o      = err;
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb/tb_inst_mem_resp.sv - scoreboard bench for inst_mem_resp
module tb_inst_mem_resp;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
`ifdef INST_MEM_LE_EN
    localparam logic [31:0] EXP_W0 = 32'h3412013C;
`else
    localparam logic [31:0] EXP_W0 = 32'h3C011234;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_resp_if #(.ADDR_W(AW)) bus();
    inst_mem_resp #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] fetch_q [$];
    int          done_q  [$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] assemble(logic [7:0] b0, logic [7:0] b1,
                                             logic [7:0] b2, logic [7:0] b3);
`ifdef INST_MEM_LE_EN
        return {b3, b2, b1, b0};
`else
        return {b0, b1, b2, b3};
`endif
    endfunction

    // Monitor: compares whatever the DUT presents against queued expectations.
    always @(negedge clk) begin
        if (fetch_q.size() > 0) begin
            chk("fetch_data", bus.rom_data_o, fetch_q.pop_front());
        end
        if (bus.ld_done_o === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: ld_done_o=1 at cycle %0d, required 0", cyc);
            end else begin
                chk("done_cycle", cyc, done_q.pop_front());
                chk("cpu_rst_at_done", bus.cpu_rst_o, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_exp(logic ce, logic [31:0] addr, logic [31:0] exp);
        bus.rom_ce_i   = ce;
        bus.rom_addr_i = addr;
        fetch_q.push_back(exp);
        step();
        bus.rom_ce_i = 1'b0;
    endtask

    task automatic fetch(logic [31:0] addr);
        logic [31:0] e;
        if (addr[31:AW+2] != '0) e = '0;
        else                     e = ref_mem[int'(addr[AW+1:2])];
        fetch_exp(1'b1, addr, e);
    endtask

    task automatic do_load(int len_in, logic [7:0] bytes [$], int gap, int abort_at);
        int          eff;
        int          nb;
        logic        rdy;
        eff = (len_in > DEPTH) ? DEPTH : len_in;
        nb  = 0;
        bus.ld_len_i   = (AW+1)'(len_in);
        bus.ld_start_i = 1'b1;
        step();
        bus.ld_start_i = 1'b0;
        if (eff == 0) begin
            done_q.push_back(cyc);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("zero_len_ready", bus.ld_ready_o, 1'b0);
                step();
            end
            return;
        end
        for (int wi = 0; wi < eff; wi++) begin
            for (int k = 0; k < 4; k++) begin
                if (gap < 0) begin
                    bus.ld_valid_i = 1'b0;
                    bus.ld_data_i  = 8'hA5;
                    step();
                end else begin
                    while ($urandom_range(99) < gap) begin
                        bus.ld_valid_i = 1'b0;
                        bus.ld_data_i  = 8'($urandom);
                        step();
                    end
                end
                bus.ld_valid_i = 1'b1;
                bus.ld_data_i  = bytes[wi*4+k];
                if (wi == 0 && k == 0) begin
                    bus.rom_ce_i   = 1'b1;
                    bus.rom_addr_i = '0;
                    fetch_q.push_back('0);
                end
                if (wi == 0 && k == 1) begin
                    bus.ld_start_i = 1'b1;
                    bus.ld_len_i   = '0;
                end
                @(negedge clk);
                rdy = bus.ld_ready_o;
                if (wi == 0 && k == 0) begin
                    chk("busy_in_load", bus.ld_busy_o, 1'b1);
                    chk("cpu_rst_in_load", bus.cpu_rst_o, 1'b1);
                end
                step();
                bus.ld_start_i = 1'b0;
                bus.rom_ce_i   = 1'b0;
                chk("ready_in_load", rdy, 1'b1);
                nb++;
                if (k == 3) begin
                    ref_mem[wi] = assemble(bytes[wi*4], bytes[wi*4+1], bytes[wi*4+2], bytes[wi*4+3]);
                    if (wi == eff - 1) done_q.push_back(cyc);
                end
                if (nb == abort_at) begin
                    bus.ld_valid_i = 1'b0;
                    #2;
                    rst = 1'b1;
                    #1;
                    chk("abort_cpu_rst", bus.cpu_rst_o, 1'b1);
                    chk("abort_ready", bus.ld_ready_o, 1'b0);
                    chk("abort_err", bus.err_o, 1'b0);
                    step();
                    rst = 1'b0;
                    step();
                    return;
                end
            end
        end
        bus.ld_valid_i = 1'b0;
    endtask

    initial begin
        logic [7:0] bq [$];
        int         n;
        bus.rom_ce_i   = 1'b0;
        bus.rom_addr_i = '0;
        bus.ld_start_i = 1'b0;
        bus.ld_len_i   = '0;
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = '0;
        step();
        step();
        chk("reset_cpu_rst", bus.cpu_rst_o, 1'b1);
        chk("reset_ready", bus.ld_ready_o, 1'b0);
        chk("reset_busy", bus.ld_busy_o, 1'b0);
        chk("reset_done", bus.ld_done_o, 1'b0);
        chk("reset_err", bus.err_o, 1'b0);
        chk("reset_rom_data", bus.rom_data_o, 32'h0);
        rst = 1'b0;
        step();
        chk("cpu_rst_released", bus.cpu_rst_o, 1'b0);

        bq = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        do_load(2, bq, 0, -1);
        step();
        fetch_exp(1'b1, 32'h0, EXP_W0);
        fetch_exp(1'b1, 32'h3, EXP_W0);
        fetch_exp(1'b1, 32'h4, 32'h0);
        fetch_exp(1'b0, 32'h0, 32'h0);

        bq = {};
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        do_load(1, bq, -1, -1);
        step();
        fetch(32'($urandom_range(0, 3)));

        repeat (6) begin
            n  = $urandom_range(1, 8);
            bq = {};
            for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
            do_load(n, bq, $urandom_range(0, 60), -1);
            step();
            for (int i = 0; i < n; i++) fetch(32'(i * 4 + $urandom_range(0, 3)));
        end

        bq = {};
        do_load(0, bq, 0, -1);
        step();

        bq = {};
        for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom));
        do_load(DEPTH + 76, bq, 0, -1);
        step();
        chk("clamp_idle_ready", bus.ld_ready_o, 1'b0);
        fetch(32'((DEPTH - 1) * 4));
        for (int i = 0; i < 8; i++) fetch(32'($urandom_range(0, DEPTH - 1) * 4));

        bq = {};
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        do_load(2, bq, 0, 6);
        fetch(32'h0);
        fetch(32'h4);

        fetch_exp(1'b0, 32'h8000_0000, 32'h0);
        chk("err_ce_low", bus.err_o, 1'b0);
        fetch_exp(1'b1, 32'h1000, 32'h0);
        chk("err_set", bus.err_o, 1'b1);
        repeat (3) step();
        chk("err_sticky", bus.err_o, 1'b1);
        fetch_exp(1'b1, {$urandom_range(1, 255), 24'h0}, 32'h0);
        fetch(32'h0);
        chk("err_still_set", bus.err_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("err_cleared_by_rst", bus.err_o, 1'b0);
        chk("rst_async_cpu_rst", bus.cpu_rst_o, 1'b1);
        step();
        rst = 1'b0;
        step();
        fetch(32'h4);

        chk("done_pending", done_q.size(), 0);
        chk("fetch_pending", fetch_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_mem_resp.md
# inst_mem_resp

Instruction-memory responder on the CPU fetch port. It answers the core's `rom_ce`/`rom_addr` requests with `rom_data` from an internal word array. A byte-stream loader port lets the bench or boot logic fill the array. While a load is running, the block holds the core in reset through `cpu_rst_o`, and releases it when the load completes.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width. Depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rom_ce_i`  in  1  fetch enable from core
- `rom_addr_i`  in  32  byte address from core PC
- `rom_data_o`  out  32  instruction word to core
- `ld_start_i`  in  1  one-cycle pulse that begins a load
- `ld_len_i`  in  ADDR_W+1  number of words to load, sampled on `ld_start_i`
- `ld_valid_i`  in  1  loader byte valid
- `ld_data_i`  in  8  loader byte
- `ld_ready_o`  out  1  block accepts a byte this cycle
- `ld_busy_o`  out  1  load in progress
- `ld_done_o`  out  1  one-cycle pulse at load completion
- `cpu_rst_o`  out  1  reset to core: `rst` OR load in progress
- `err_o`  out  1  sticky: an enabled fetch fell outside the array

## Operation
- FSM states: IDLE, LOAD, DONE. Reset puts the FSM in IDLE.
- **IDLE**
  - `ld_start_i` with `ld_len_i` = 0 → DONE.
  - `ld_start_i` with nonzero `ld_len_i` → LOAD. The block latches len, clamped to 2^ADDR_W, and clears the word counter and byte counter.
- **LOAD**
  - A byte transfers on a cycle where `ld_valid_i` && `ld_ready_o`.
  - Transferred bytes shift into a 32-bit assembly register, first byte → bits 31:24 (big-endian, MIPS order).
  - On the 4th byte, the assembled word is written at word index = word counter, the byte counter wraps to 0, and the word counter increments.
  - When the word written is index len-1 → DONE.
  - `ld_start_i` is ignored while in LOAD.
- **DONE**
  - `ld_done_o`=1 for one cycle, then IDLE.
- **Fetch**
  - `rom_data_o` is a combinational read of word `rom_addr_i[ADDR_W+1:2]`.
  - `rom_addr_i[1:0]` is ignored.
  - `rom_data_o` = 0 when `rom_ce_i`=0, when the state is LOAD, or when `rom_addr_i[31:ADDR_W+2]` ≠ 0.
- **err_o**
  - Set on any clock edge where `rom_ce_i`=1, the state is not LOAD, and the address is out of range.
  - Cleared only by `rst`.
- **Array**
  - The memory array is not reset; its contents persist across `rst`.
  - Words beyond len keep their prior value.

## Timing
Reset values:
- `ld_ready_o`=0, `ld_busy_o`=0, `ld_done_o`=0, `err_o`=0
- `cpu_rst_o`=1, asserted asynchronously with `rst`
- `rom_data_o`: combinational; 0 while `rom_ce_i`=0

Load timing:
- `ld_ready_o` = `ld_busy_o` = (state==LOAD), registered state.
  - Start pulse at edge N → ready from cycle N+1.
- Throughput is one byte per cycle. A load of L words takes 4L accepted bytes.
  - The last word is written at the edge that accepts its 4th byte.
  - `ld_done_o` is high the following cycle.
- `cpu_rst_o`: high from the cycle after the start pulse through the last LOAD cycle. Low in DONE, so the core leaves reset the cycle `ld_done_o` is high.

Fetch timing:
- Zero-latency combinational path, `rom_addr_i`/`rom_ce_i` → `rom_data_o`.
- A word written at edge N is visible on `rom_data_o` from cycle N+1.

Boundary conditions:
- `rst` mid-load aborts immediately. A partially assembled word is discarded; words already written remain.
- `ld_valid_i` may drop mid-word; the byte counter holds.
- `ld_len_i` > 2^ADDR_W: clamped to 2^ADDR_W; the word counter never wraps.

## Configuration
- `INST_MEM_LE_EN`
  - Defined: byte assembly is little-endian (first byte → bits 7:0, 4th byte → bits 31:24).
  - Undefined (default): big-endian as described in Operation.
  - Fetch path, FSM and timing are identical in both builds.

## Test plan
- **Reset:** assert `rst` mid-cycle.
  - → `cpu_rst_o`=1 asynchronously.
  - → `ld_ready_o`=0, `err_o`=0.
- **Load 2 words:** `ld_len_i`=2, bytes 3C,01,12,34,00,00,00,00.
  - → word0=3C011234, word1=00000000.
  - → `ld_done_o` pulses 1 cycle after the 8th byte.
  - → `cpu_rst_o` falls the same cycle.
  - With `INST_MEM_LE_EN`: word0=3412013C.
- **Fetch:** after the load, `rom_ce_i`=1, `rom_addr_i`=0x0 → 3C011234 same cycle.
  - `rom_addr_i`=0x3 → 3C011234.
  - `rom_ce_i`=0 → 0.
- **Gapped valid:** `ld_valid_i` toggles every other cycle during a 1-word load → correct word, 4 accepted bytes, done after 4th.
- **Out of range** (ADDR_W=10): fetch at `rom_addr_i`=0x1000 → `rom_data_o`=0, `err_o`=1 next cycle, stays 1 until `rst`.
- **Abort/zero length:**
  - `rst` after 2 bytes of word1 → word0 retained, word1 unchanged.
  - `ld_len_i`=0 start → `ld_done_o` next cycle, `ld_ready_o` never 1.
